// File: rtl/bnn_pkg.sv
// Shared constants and state types for the BNN byte-to-bit transmitter and its loader.
// Bit totals here define the loader's image and weight array sizes.
package bnn_pkg;

  localparam int PIX_BITS  = 784;
  localparam int W1_BITS   = 72;
  localparam int W2_BITS   = 288;
  localparam int W3_BITS   = 1960;
  localparam int W_BITS    = W1_BITS + W2_BITS + W3_BITS;
  localparam int PIX_BYTES = PIX_BITS / 8;
  localparam int W_BYTES   = W_BITS / 8;

  localparam int PIX_CNT_W = $clog2(PIX_BITS + 1);
  localparam int W_CNT_W   = $clog2(W_BITS + 1);

  // Loader state code that the system top selects whenever load_en is high.
  localparam logic [2:0] s_LOAD = 3'b001;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
  } tx_state_e;

endpackage

// File: rtl/bnn_stream_tx_if.sv
// Pixel and weight byte channels between the host and the transmitter.
interface bnn_stream_tx_if;

  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] wgt_data;
  logic       wgt_valid;
  logic       wgt_ready;

  modport master (
    output pix_data, pix_valid, wgt_data, wgt_valid,
    input  pix_ready, wgt_ready
  );

  modport slave (
    input  pix_data, pix_valid, wgt_data, wgt_valid,
    output pix_ready, wgt_ready
  );

endinterface

// File: rtl/bnn_tx_lane.sv
// One serializer lane: single-byte buffer shifted out LSB first, with byte-count limit
// and a ready that only depends on registered state plus the (registered) consume flag.
module bnn_tx_lane #(
  parameter int BYTE_LIMIT = 98
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       active,
  input  logic       consume,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       bit0,
  output logic       nonempty
);

  localparam int CW = $clog2(BYTE_LIMIT + 1);

  logic [7:0]    r_sr;
  logic [3:0]    r_fill;
  logic [CW-1:0] r_bytes;
  logic          w_accept;

  // A new byte may land in the same cycle the last buffered bit leaves, so the
  // stream never bubbles while valid is held.
  assign ready    = active && (r_bytes < CW'(BYTE_LIMIT)) &&
                    ((r_fill == 4'd0) || ((r_fill == 4'd1) && consume));
  assign w_accept = ready && valid;
  assign bit0     = r_sr[0];
  assign nonempty = (r_fill != 4'd0);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr    <= '0;
      r_fill  <= '0;
      r_bytes <= '0;
    end else if (clear) begin
      r_sr    <= '0;
      r_fill  <= '0;
      r_bytes <= '0;
    end else if (w_accept) begin
      r_sr    <= data;
      r_fill  <= 4'd8;
      r_bytes <= r_bytes + CW'(1);
    end else if (consume) begin
      r_sr    <= {1'b0, r_sr[7:1]};
      r_fill  <= r_fill - 4'd1;
    end
  end

endmodule

// File: rtl/bnn_stream_tx.sv
// Streams host pixel/weight bytes into the BNN loader as two serial bit lanes,
// one bit per lane per load_en cycle, in the loader's own index order.
module bnn_stream_tx
  import bnn_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  bnn_stream_tx_if.slave   bus,
  output logic             d_out_p,
  output logic             d_out_w,
  output logic             load_en,
  output logic             busy,
  output logic             done
);

  tx_state_e              r_state;
  logic                   r_busy;
  logic                   r_done;
  logic [PIX_CNT_W-1:0]   r_pix_bits;
  logic [W_CNT_W-1:0]     r_w_bits;

  logic w_send;
  logic w_clear;
  logic w_pix_live;
  logic w_load;
  logic w_p_consume;
  logic w_p_bit;
  logic w_p_nonempty;
  logic w_w_bit;
  logic w_w_nonempty;

  assign w_send      = (r_state == TX_SEND);
  assign w_clear     = (r_state == TX_IDLE) && start;
  assign w_pix_live  = (r_pix_bits < PIX_CNT_W'(PIX_BITS));
  // Pixels run out at 784 bits; after that only the weight lane gates the loader.
  assign w_load      = w_send && w_w_nonempty && (w_p_nonempty || !w_pix_live);
  assign w_p_consume = w_load && w_pix_live;

  bnn_tx_lane #(.BYTE_LIMIT(PIX_BYTES)) u_pix_lane (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .active   (w_send),
    .consume  (w_p_consume),
    .data     (bus.pix_data),
    .valid    (bus.pix_valid),
    .ready    (bus.pix_ready),
    .bit0     (w_p_bit),
    .nonempty (w_p_nonempty)
  );

  bnn_tx_lane #(.BYTE_LIMIT(W_BYTES)) u_wgt_lane (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (w_clear),
    .active   (w_send),
    .consume  (w_load),
    .data     (bus.wgt_data),
    .valid    (bus.wgt_valid),
    .ready    (bus.wgt_ready),
    .bit0     (w_w_bit),
    .nonempty (w_w_nonempty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= TX_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pix_bits <= '0;
      r_w_bits   <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (start) begin
            r_state    <= TX_SEND;
            r_busy     <= 1'b1;
            r_pix_bits <= '0;
            r_w_bits   <= '0;
          end
        end
        TX_SEND: begin
          if (w_load) begin
            r_w_bits <= r_w_bits + W_CNT_W'(1);
            if (w_pix_live)
              r_pix_bits <= r_pix_bits + PIX_CNT_W'(1);
            if (r_w_bits == W_CNT_W'(W_BITS - 1)) begin
              r_state <= TX_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        TX_DONE: begin
          r_state <= TX_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= TX_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign load_en = w_load;
  assign d_out_p = w_p_consume && w_p_bit;
  assign d_out_w = w_load && w_w_bit;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_bnn_stream_tx.sv
// Scoreboard bench for bnn_stream_tx: drivers push expected bits per accepted byte,
// a negedge monitor pops and compares on every load_en cycle.
module tb_bnn_stream_tx;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic d_out_p, d_out_w, load_en, busy, done;

  bnn_stream_tx_if u_if ();

  bnn_stream_tx u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bus     (u_if.slave),
    .d_out_p (d_out_p),
    .d_out_w (d_out_w),
    .load_en (load_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  bit pix_q[$];
  bit wgt_q[$];

  int cyc = 0;
  bit mon_en = 0;
  int le_count, le_run, le_run_max, first_le, last_le;
  int done_count, done_cyc, busy_count, gap_count;
  int pix_hs, wgt_hs, pix_over, mon_pix_bits, mon_w_bits;
  logic [7:0] first_pix;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] pix_byte(input int pat, input int i);
    if (pat == 0) return 8'(i + 1);
    return 8'(i * 13) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] wgt_byte(input int pat, input int i);
    if (pat == 0) return 8'(i * 37 + 5);
    return 8'(i * 91 + 17) ^ 8'hC3;
  endfunction

  task automatic clear_stats();
    le_count = 0; le_run = 0; le_run_max = 0; first_le = -1; last_le = -1;
    done_count = 0; done_cyc = -1; busy_count = 0; gap_count = 0;
    pix_hs = 0; wgt_hs = 0; pix_over = 0; mon_pix_bits = 0; mon_w_bits = 0;
    first_pix = '0;
    pix_q.delete();
    wgt_q.delete();
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (reset_n && mon_en) begin
      bit exp_p, exp_w;
      if (busy) busy_count++;
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (u_if.pix_ready && pix_hs >= PIX_BYTES) pix_over++;
      if (u_if.pix_ready && u_if.pix_valid) pix_hs++;
      if (u_if.wgt_ready && u_if.wgt_valid) wgt_hs++;
      if (load_en) begin
        if (first_le < 0) first_le = cyc;
        last_le = cyc;
        le_count++;
        le_run++;
        if (le_run > le_run_max) le_run_max = le_run;
        exp_p = 1'b0;
        if (mon_pix_bits < PIX_BITS) begin
          if (pix_q.size() == 0) check("pix_q_underflow", 32'd1, 32'd0);
          else exp_p = pix_q.pop_front();
          if (mon_pix_bits < 8) first_pix[mon_pix_bits] = d_out_p;
          mon_pix_bits++;
        end
        check("d_out_p", 32'(d_out_p), 32'(exp_p));
        exp_w = 1'b0;
        if (wgt_q.size() == 0) check("wgt_q_underflow", 32'd1, 32'd0);
        else exp_w = wgt_q.pop_front();
        check("d_out_w", 32'(d_out_w), 32'(exp_w));
        mon_w_bits++;
      end else begin
        le_run = 0;
        if (busy) gap_count++;
        check("idle_dout", 32'({d_out_p, d_out_w}), 32'd0);
      end
    end
  end

  task automatic drive_pix(input int n, input int pat);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      u_if.pix_data  = pix_byte(pat, i);
      u_if.pix_valid = 1'b1;
      for (int k = 0; k < 5000; k++) begin
        @(negedge clk);
        if (u_if.pix_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        check("pix_handshake_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge clk);
      for (int b = 0; b < 8; b++) pix_q.push_back(pix_byte(pat, i) >> b & 8'd1);
      #1;
    end
    // Keep offering data past the limit; the DUT must refuse it.
    u_if.pix_data  = 8'hFF;
    u_if.pix_valid = 1'b1;
  endtask

  task automatic drive_wgt(input int n, input int pat, input int stall_byte);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      if (i == stall_byte) begin
        u_if.wgt_valid = 1'b0;
        for (int k = 0; k < 5000; k++) begin
          @(negedge clk);
          if (u_if.wgt_ready) begin
            ok = 1;
            break;
          end
        end
        if (!ok) begin
          check("wgt_stall_timeout", 32'd0, 32'd1);
          return;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        ok = 0;
      end
      u_if.wgt_data  = wgt_byte(pat, i);
      u_if.wgt_valid = 1'b1;
      for (int k = 0; k < 5000; k++) begin
        @(negedge clk);
        if (u_if.wgt_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        check("wgt_handshake_timeout", 32'd0, 32'd1);
        return;
      end
      @(posedge clk);
      for (int b = 0; b < 8; b++) wgt_q.push_back(wgt_byte(pat, i) >> b & 8'd1);
      #1;
    end
    u_if.wgt_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_en"}, 32'(load_en), 32'd0);
    check({tag, "_dout"}, 32'({d_out_p, d_out_w}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ready"}, 32'({u_if.pix_ready, u_if.wgt_ready}), 32'd0);
  endtask

  // One transfer. abort_bit >= 0 asserts reset once that many weight bits are out.
  task automatic run_stream(input int pat, input int wgt_n, input int stall_byte,
                            input int abort_bit, input bit pulse_start,
                            input logic [7:0] exp_first_pix, input int exp_gaps);
    int start_cyc;
    bit ok;
    clear_stats();
    mon_en = 1;
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      drive_pix(PIX_BYTES, pat);
      drive_wgt(wgt_n, pat, stall_byte);
      begin
        if (pulse_start) begin
          repeat (300) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    ok = 0;
    if (abort_bit >= 0) begin
      for (int k = 0; k < 6000; k++) begin
        if (mon_w_bits >= abort_bit) begin
          ok = 1;
          break;
        end
        @(posedge clk);
      end
      check("abort_reach", 32'(ok), 32'd1);
      #2;
      reset_n = 1'b0;
      mon_en  = 1'b0;
      u_if.pix_valid = 1'b0;
      u_if.wgt_valid = 1'b0;
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle_busy", 32'(busy), 32'd0);
      check("post_rst_idle_load", 32'(load_en), 32'd0);
    end else begin
      for (int k = 0; k < 6000; k++) begin
        @(posedge clk);
        if (done_count > 0) begin
          ok = 1;
          break;
        end
      end
      check("done_seen", 32'(ok), 32'd1);
      repeat (3) @(posedge clk);
      mon_en = 0;
      u_if.pix_valid = 1'b0;
      check("first_le_latency", 32'(first_le - start_cyc), 32'd2);
      check("load_en_count", 32'(le_count), 32'(W_BITS));
      check("gap_count", 32'(gap_count), 32'(exp_gaps));
      check("busy_cycles", 32'(busy_count), 32'(W_BITS + exp_gaps));
      if (exp_gaps == 1) check("le_run_max", 32'(le_run_max), 32'(W_BITS));
      check("done_after_last_le", 32'(done_cyc - last_le), 32'd1);
      check("done_pulse_len", 32'(done_count), 32'd1);
      check("pix_bytes", 32'(pix_hs), 32'(PIX_BYTES));
      check("wgt_bytes", 32'(wgt_hs), 32'(W_BYTES));
      check("pix_ready_after_limit", 32'(pix_over), 32'd0);
      check("first_pix_bits", 32'(first_pix), 32'(exp_first_pix));
      check("sb_pix_empty", 32'(pix_q.size()), 32'd0);
      check("sb_wgt_empty", 32'(wgt_q.size()), 32'd0);
      @(negedge clk);
      check("end_busy", 32'(busy), 32'd0);
      check("end_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    u_if.pix_data  = 8'hA5;
    u_if.pix_valid = 1'b1;
    u_if.wgt_data  = 8'h5A;
    u_if.wgt_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    start = 1'b0;
    u_if.pix_valid = 1'b0;
    u_if.wgt_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Full stream, pixels 0x01,0x02..., stray start during SEND.
    run_stream(0, W_BYTES, -1, -1, 1'b1, 8'h01, 1);
    // Weight channel starved for 5 cycles at byte 150.
    run_stream(1, W_BYTES, 150, -1, 1'b0, 8'h5A, 6);
    // Reset at weight bit 1000, then a clean restart from bit 0.
    run_stream(0, 126, -1, 1000, 1'b0, 8'h01, 1);
    run_stream(1, W_BYTES, -1, -1, 1'b0, 8'h5A, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
